// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
package clk_div_pkg;

   localparam int          CNT_W_DEF    = 24;
   localparam int unsigned DEF_HALF_DEF = 10_000_000;

   // A half-period of 0 behaves like 1: toggle on every enabled cycle.
   function automatic logic [31:0] eff_half(input logic [31:0] half);
      return (half == 32'd0) ? 32'd1 : half;
   endfunction

   // Channel-select width; a single-channel bank still gets a 1-bit select.
   function automatic int sel_width(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_div_ch.sv
// rtl/clk_div_ch.sv - one divider channel; CLK_DIV_BANK_SHADOW_EN selects shadowed half-period writes
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int               CNT_W    = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(DEF_HALF_DEF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             we,
   input  logic [CNT_W-1:0] wdata,
   output logic [CNT_W-1:0] half,
   output logic             tick,
   output logic             clk_out
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [CNT_W-1:0] eff;
   logic             term;
`ifdef CLK_DIV_BANK_SHADOW_EN
   logic [CNT_W-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;
   logic             apply;
`endif

   // Terminal compare is >= so a half-period shrunk below cnt ends the period at once.
   assign eff  = CNT_W'(eff_half(32'(half_q)));
   assign term = (cnt_q >= (eff - CNT_W'(1)));

   // Next-state: sync beats enable, enable gates counting, then half-period update.
   always_comb begin
      cnt_d     = cnt_q;
      clk_out_d = clk_out_q;
      tick_d    = 1'b0;
      half_d    = half_q;
      if (sync) begin
         cnt_d     = '0;
         clk_out_d = 1'b0;
      end else if (en) begin
         if (term) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
`ifdef CLK_DIV_BANK_SHADOW_EN
      shadow_d = shadow_q;
      pend_d   = pend_q;
      // New value only lands at a period boundary, so each clk_out level is whole.
      apply    = sync | ~en | term;
      if (apply) begin
         if (we) begin
            half_d = wdata;
         end else if (pend_q) begin
            half_d = shadow_q;
         end
         pend_d = 1'b0;
      end else if (we) begin
         shadow_d = wdata;
         pend_d   = 1'b1;
      end
`else
      if (we) begin
         half_d = wdata;
      end
`endif
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         half_q    <= DEF_HALF;
         clk_out_q <= 1'b0;
         tick_q    <= 1'b0;
`ifdef CLK_DIV_BANK_SHADOW_EN
         shadow_q  <= '0;
         pend_q    <= 1'b0;
`endif
      end else begin
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         clk_out_q <= clk_out_d;
         tick_q    <= tick_d;
`ifdef CLK_DIV_BANK_SHADOW_EN
         shadow_q  <= shadow_d;
         pend_q    <= pend_d;
`endif
      end
   end

   assign half    = half_q;
   assign tick    = tick_q;
   assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of N_CH clock dividers; CLK_DIV_BANK_SHADOW_EN enables shadowed writes
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int          N_CH     = 4,
   parameter int          CNT_W    = CNT_W_DEF,
   parameter int unsigned DEF_HALF = DEF_HALF_DEF,
   localparam int         SEL_W    = sel_width(N_CH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_CH-1:0]  en,
   input  logic             sync,
   input  logic             div_we,
   input  logic [SEL_W-1:0] div_sel,
   input  logic [CNT_W-1:0] div_wdata,
   output logic [CNT_W-1:0] div_rdata,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  clk_out
);

   logic [N_CH-1:0]  we_vec;
   logic [CNT_W-1:0] half_vec [N_CH];

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Out-of-range selects never match any channel, so they are dropped.
      assign we_vec[i] = div_we && (div_sel == SEL_W'(i));

      clk_div_ch #(
         .CNT_W    (CNT_W),
         .DEF_HALF (CNT_W'(DEF_HALF))
      ) u_ch (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en[i]),
         .sync    (sync),
         .we      (we_vec[i]),
         .wdata   (div_wdata),
         .half    (half_vec[i]),
         .tick    (tick[i]),
         .clk_out (clk_out[i])
      );
   end

   // Readback of the active half-period of the selected channel.
   always_comb begin
      div_rdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (div_sel == SEL_W'(i)) begin
            div_rdata = half_vec[i];
         end
      end
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank
module tb_clk_div_bank;

   localparam int          N_CH     = 5;
   localparam int          CNT_W    = 24;
   localparam int unsigned DEF_HALF = 10_000_000;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N_CH-1:0]  en = '0;
   logic             sync = 1'b0;
   logic             div_we = 1'b0;
   logic [2:0]       div_sel = '0;
   logic [CNT_W-1:0] div_wdata = '0;
   logic [CNT_W-1:0] div_rdata;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  clk_out;

   int checks = 0;
   int errors = 0;

   int unsigned m_cnt    [N_CH];
   int unsigned m_half   [N_CH];
   int unsigned m_shadow [N_CH];
   bit          m_pend   [N_CH];
   bit          m_clk    [N_CH];
   bit          m_tick   [N_CH];

   clk_div_bank #(
      .N_CH     (N_CH),
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .sync      (sync),
      .div_we    (div_we),
      .div_sel   (div_sel),
      .div_wdata (div_wdata),
      .div_rdata (div_rdata),
      .tick      (tick),
      .clk_out   (clk_out)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < N_CH; i++) begin
         m_cnt[i] = 0; m_half[i] = DEF_HALF; m_shadow[i] = 0;
         m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end
   endtask

   task automatic model_step();
      int unsigned eff;
      bit hit, term;
      for (int i = 0; i < N_CH; i++) begin
         eff  = (m_half[i] == 0) ? 1 : m_half[i];
         hit  = div_we && (int'(div_sel) == i);
         term = en[i] && (m_cnt[i] + 1 >= eff);
         if (sync) begin
            m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
         end else if (!en[i]) begin
            m_tick[i] = 0;
         end else if (term) begin
            m_cnt[i] = 0; m_clk[i] = !m_clk[i]; m_tick[i] = 1;
         end else begin
            m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
         end
`ifdef CLK_DIV_BANK_SHADOW_EN
         if (sync || !en[i] || term) begin
            if (hit) m_half[i] = div_wdata;
            else if (m_pend[i]) m_half[i] = m_shadow[i];
            m_pend[i] = 0;
         end else if (hit) begin
            m_shadow[i] = div_wdata; m_pend[i] = 1;
         end
`else
         if (hit) m_half[i] = div_wdata;
`endif
      end
   endtask

   function automatic logic [N_CH-1:0] m_tick_vec();
      logic [N_CH-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i] = m_tick[i];
      return v;
   endfunction

   function automatic logic [N_CH-1:0] m_clk_vec();
      logic [N_CH-1:0] v;
      for (int i = 0; i < N_CH; i++) v[i] = m_clk[i];
      return v;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; en = '0; sync = 1'b0; div_we = 1'b0; div_sel = '0; div_wdata = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic wr(input int ch, input int val);
      div_we = 1'b1; div_sel = 3'(ch); div_wdata = CNT_W'(val);
      cyc();
      div_we = 1'b0;
   endtask

   task automatic test_reset();
      reset_dut();
      checks++;
      if (tick !== '0 || clk_out !== '0) begin
         errors++;
         $display("FAIL reset_out: tick=%b clk_out=%b expected 0", tick, clk_out);
      end
      for (int i = 0; i < N_CH; i++) begin
         div_sel = 3'(i);
         #1;
         checks++;
         if (div_rdata !== CNT_W'(DEF_HALF)) begin
            errors++;
            $display("FAIL reset_half ch%0d: got %0d expected %0d", i, div_rdata, DEF_HALF);
         end
      end
   endtask

   task automatic test_half4();
      logic et, ec;
      reset_dut();
      wr(0, 4);
      en = 5'b00001;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         et = (k % 4 == 0);
         ec = ((k / 4) % 2 == 1);
         checks++;
         if (tick[0] !== et || clk_out[0] !== ec) begin
            errors++;
            $display("FAIL half4 edge%0d: tick=%b clk_out=%b expected %b %b", k, tick[0], clk_out[0], et, ec);
         end
      end
   endtask

   task automatic test_half01();
      logic ec;
      reset_dut();
      wr(1, 0);
      en = 5'b00010;
      ec = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 4) begin
            div_we = 1'b1; div_sel = 3'd1; div_wdata = CNT_W'(1);
         end
         cyc();
         div_we = 1'b0;
         ec = ~ec;
         checks++;
         if (tick[1] !== 1'b1 || clk_out[1] !== ec) begin
            errors++;
            $display("FAIL half01 edge%0d: tick=%b clk_out=%b expected 1 %b", k, tick[1], clk_out[1], ec);
         end
      end
      div_sel = 3'd1;
      #1;
      checks++;
      if (div_rdata !== CNT_W'(1)) begin
         errors++;
         $display("FAIL half01_rdata: got %0d expected 1", div_rdata);
      end
   endtask

   task automatic test_en_gap();
      logic et, ec;
      reset_dut();
      wr(2, 10);
      for (int k = 1; k <= 14; k++) begin
         en = (k <= 5 || k >= 9) ? 5'b00100 : 5'b00000;
         cyc();
         et = (k == 13);
         ec = (k >= 13);
         checks++;
         if (tick[2] !== et || clk_out[2] !== ec) begin
            errors++;
            $display("FAIL en_gap edge%0d: tick=%b clk_out=%b expected %b %b", k, tick[2], clk_out[2], et, ec);
         end
      end
   endtask

   task automatic test_shrink();
      logic et, ec;
      int first;
`ifdef CLK_DIV_BANK_SHADOW_EN
      first = 100;
`else
      first = 52;
`endif
      reset_dut();
      wr(0, 100);
      en = 5'b00001;
      ec = 1'b0;
      for (int k = 1; k <= 120; k++) begin
         if (k == 51) begin
            div_we = 1'b1; div_sel = 3'd0; div_wdata = CNT_W'(8);
         end
         cyc();
         div_we = 1'b0;
         et = (k >= first) && ((k - first) % 8 == 0);
         if (et) ec = ~ec;
         checks++;
         if (tick[0] !== et || clk_out[0] !== ec) begin
            errors++;
            $display("FAIL shrink edge%0d: tick=%b clk_out=%b expected %b %b", k, tick[0], clk_out[0], et, ec);
         end
      end
   endtask

   task automatic test_sync();
      int h [N_CH] = '{3, 5, 3, 7, 3};
      int n;
      logic [N_CH-1:0] et, ec;
      reset_dut();
      for (int i = 0; i < N_CH; i++) wr(i, h[i]);
      n = $urandom_range(10, 40);
      for (int k = 0; k < n; k++) begin
         en = N_CH'($urandom);
         cyc();
      end
      en = '1;
      for (int k = 0; k < 16 && m_clk_vec() == '0; k++) cyc();
      checks++;
      if (tick !== m_tick_vec() || clk_out !== m_clk_vec() || clk_out == '0) begin
         errors++;
         $display("FAIL sync_pre: tick=%b clk_out=%b expected %b %b (nonzero)", tick, clk_out, m_tick_vec(), m_clk_vec());
      end
      sync = 1'b1;
      en = N_CH'($urandom);
      cyc();
      sync = 1'b0;
      checks++;
      if (tick !== '0 || clk_out !== '0) begin
         errors++;
         $display("FAIL sync_clear: tick=%b clk_out=%b expected 0 0", tick, clk_out);
      end
      en = '1;
      for (int k = 1; k <= 42; k++) begin
         cyc();
         for (int i = 0; i < N_CH; i++) begin
            et[i] = (k % h[i] == 0);
            ec[i] = ((k / h[i]) % 2 == 1);
         end
         checks++;
         if (tick !== et || clk_out !== ec) begin
            errors++;
            $display("FAIL sync_align edge%0d: tick=%b clk_out=%b expected %b %b", k, tick, clk_out, et, ec);
         end
      end
   endtask

   task automatic test_random();
      reset_dut();
      for (int k = 0; k < 400; k++) begin
         en        = N_CH'($urandom);
         sync      = ($urandom_range(0, 19) == 0);
         div_we    = ($urandom_range(0, 2) == 0);
         div_sel   = 3'($urandom_range(0, 7));
         div_wdata = CNT_W'($urandom_range(0, 12));
         cyc();
         checks++;
         if (tick !== m_tick_vec() || clk_out !== m_clk_vec()) begin
            errors++;
            $display("FAIL random cyc%0d: tick=%b clk_out=%b expected %b %b", k, tick, clk_out, m_tick_vec(), m_clk_vec());
         end
         if (int'(div_sel) < N_CH) begin
            checks++;
            if (div_rdata !== CNT_W'(m_half[div_sel])) begin
               errors++;
               $display("FAIL random_rdata cyc%0d ch%0d: got %0d expected %0d", k, div_sel, div_rdata, m_half[div_sel]);
            end
         end
      end
      sync = 1'b0; div_we = 1'b0;
   endtask

   task automatic test_async_reset();
      reset_dut();
      wr(0, 2);
      en = 5'b00001;
      cyc();
      cyc();
      checks++;
      if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: tick=%b clk_out=%b expected 1 1", tick[0], clk_out[0]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tick !== '0 || clk_out !== '0) begin
         errors++;
         $display("FAIL arst_out: tick=%b clk_out=%b expected 0 0", tick, clk_out);
      end
      div_sel = 3'd0;
      #1;
      checks++;
      if (div_rdata !== CNT_W'(DEF_HALF)) begin
         errors++;
         $display("FAIL arst_half: got %0d expected %0d", div_rdata, DEF_HALF);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      en = '0;
      model_reset();
      wr(5, 7);
      wr(6, 7);
      wr(7, 7);
      for (int i = 0; i < N_CH; i++) begin
         div_sel = 3'(i);
         #1;
         checks++;
         if (div_rdata !== CNT_W'(DEF_HALF)) begin
            errors++;
            $display("FAIL oor_write ch%0d: got %0d expected %0d", i, div_rdata, DEF_HALF);
         end
      end
   endtask

   initial begin
      test_reset();
      test_half4();
      test_half01();
      test_en_gap();
      test_shrink();
      test_sync();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
